sva_req_pulse_mon: RTL and testbench

- Parametrised multi-channel request-pulse protocol monitor.
- Generalises the single-channel rule "req high for one cycle, then low" (req |=> !req) to NUM_CH channels, with a configurable maximum high time and minimum low gap per pulse.
- Reports violations as registered error pulses, sticky flags and a saturating error counter.
- Sits beside any requester/arbiter in simulation benches; also synthesisable for on-chip debug.

---
 rtl/sva_pulse_mon_pkg.sv | 13 +
 rtl/sva_pulse_chan.sv | 94 +++++++++
 rtl/sva_req_pulse_mon.sv | 90 +++++++++
 tb/tb_sva_req_pulse_mon.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/sva_pulse_mon_pkg.sv
// Shared types and constants for the request-pulse monitor.
package sva_pulse_mon_pkg;

    typedef enum logic [1:0] {IDLE, HIGH, STUCK, COOL} pulse_st_e;

    localparam logic ERR_OVERLONG = 1'b1;
    localparam logic ERR_SHORTGAP = 1'b0;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sva_pulse_chan.sv
// One channel of the request-pulse monitor: FSM plus run-length counter.
// viol/kind are combinational and describe the rule broken at the coming edge.
module sva_pulse_chan
    import sva_pulse_mon_pkg::*;
#(
    parameter int unsigned MAX_HIGH = 1,
    parameter int unsigned MIN_LOW  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req,
    output logic viol,
    output logic kind,
    output logic busy
);

    localparam int unsigned RUN_W = $clog2(max2(MAX_HIGH, MIN_LOW) + 1);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [RUN_W-1:0] MAX_R   = RUN_W'(MAX_HIGH);
    localparam logic [RUN_W-1:0] MIN_R   = RUN_W'(MIN_LOW);

    pulse_st_e        state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        viol    = 1'b0;
        kind    = ERR_SHORTGAP;
        if (!en) begin
            state_d = IDLE;
            run_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_d = HIGH;
                        run_d   = RUN_ONE;
                    end
                end
                HIGH: begin
                    if (!req) begin
                        state_d = COOL;
                        run_d   = RUN_ONE;
                    end else if (run_q == MAX_R) begin
                        viol    = 1'b1;
                        kind    = ERR_OVERLONG;
                        state_d = STUCK;
                    end else begin
                        run_d = run_q + RUN_ONE;
                    end
                end
                STUCK: begin
                    // Only one overlong report per pulse, however long req stays up.
                    if (!req) begin
                        state_d = COOL;
                        run_d   = RUN_ONE;
                    end
                end
                COOL: begin
                    if (req) begin
                        viol    = (run_q != MIN_R);
                        kind    = ERR_SHORTGAP;
                        state_d = HIGH;
                        run_d   = RUN_ONE;
                    end else if (run_q == MIN_R) begin
                        state_d = IDLE;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + RUN_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: rtl/sva_req_pulse_mon.sv
// Multi-channel request-pulse protocol monitor with registered error reporting.
// Optional SVA checks are compiled in with SVA_PULSE_ASSERT_EN.
module sva_req_pulse_mon
    import sva_pulse_mon_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned MAX_HIGH = 1,
    parameter int unsigned MIN_LOW  = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] req,
    input  logic              clr_err,
    output logic [NUM_CH-1:0] err_pulse,
    output logic [NUM_CH-1:0] err_kind,
    output logic [NUM_CH-1:0] err_sticky,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              busy
);

    localparam int unsigned PC_W  = $clog2(NUM_CH + 1);
    localparam int unsigned SUM_W = max2(CNT_W, PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0] viol, kind, chan_busy;
    logic [PC_W-1:0]   pc;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt_d;
    logic [NUM_CH-1:0] sticky_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        sva_pulse_chan #(
            .MAX_HIGH(MAX_HIGH),
            .MIN_LOW (MIN_LOW)
        ) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (en),
            .req  (req[i]),
            .viol (viol[i]),
            .kind (kind[i]),
            .busy (chan_busy[i])
        );
    end

    always_comb begin
        pc = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pc = pc + PC_W'(viol[i]);
        end
        // Clear takes effect before this cycle's violations are added.
        sum      = (clr_err ? '0 : SUM_W'(err_cnt)) + SUM_W'(pc);
        cnt_d    = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
        sticky_d = (clr_err ? '0 : err_sticky) | viol;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse  <= '0;
            err_kind   <= '0;
            err_sticky <= '0;
            err_cnt    <= '0;
        end else begin
            err_pulse  <= viol;
            err_kind   <= viol & kind;
            err_sticky <= sticky_d;
            err_cnt    <= cnt_d;
        end
    end

    assign busy = |chan_busy;

`ifdef SVA_PULSE_ASSERT_EN
    for (genvar i = 0; i < NUM_CH; i++) begin : g_sva
        a_overlong: assert property (@(posedge clk) disable iff (!rst_n || !en)
            $rose(req[i]) |-> ##[1:MAX_HIGH] !req[i])
            else $error("ch%0d overlong high", i);
        a_shortgap: assert property (@(posedge clk) disable iff (!rst_n || !en)
            $fell(req[i]) |-> !req[i] [*MIN_LOW])
            else $error("ch%0d short low gap", i);
        c_legal: cover property (@(posedge clk) disable iff (!rst_n || !en)
            $rose(req[i]) ##0 req[i] [*1:MAX_HIGH] ##1 !req[i] [*MIN_LOW]);
    end
`else
    // No protocol assertions in this build; monitor outputs are unaffected.
`endif

endmodule

// File: tb/tb_sva_req_pulse_mon.sv
// Directed self-checking bench for sva_req_pulse_mon (three parameterisations).
module tb_sva_req_pulse_mon;

    logic clk = 1'b0;
    logic rst_n, en, clr_err;
    logic [3:0] req_a, req_b, req_c;

    logic [3:0] pulse_a, kind_a, sticky_a, pulse_b, kind_b, sticky_b, pulse_c, kind_c, sticky_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic       busy_a, busy_b, busy_c;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    sva_req_pulse_mon u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req_a), .clr_err(clr_err),
        .err_pulse(pulse_a), .err_kind(kind_a), .err_sticky(sticky_a),
        .err_cnt(cnt_a), .busy(busy_a)
    );

    sva_req_pulse_mon #(.MAX_HIGH(3), .MIN_LOW(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req_b), .clr_err(clr_err),
        .err_pulse(pulse_b), .err_kind(kind_b), .err_sticky(sticky_b),
        .err_cnt(cnt_b), .busy(busy_b)
    );

    sva_req_pulse_mon #(.CNT_W(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req_c), .clr_err(clr_err),
        .err_pulse(pulse_c), .err_kind(kind_c), .err_sticky(sticky_c),
        .err_cnt(cnt_c), .busy(busy_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; clr_err = 1'b0;
        req_a = '0; req_b = '0; req_c = '0;
        #2;
        check("rst_pulse",  32'(pulse_a),  0);
        check("rst_kind",   32'(kind_a),   0);
        check("rst_sticky", 32'(sticky_a), 0);
        check("rst_cnt",    32'(cnt_a),    0);
        check("rst_busy",   32'(busy_a),   0);
        step();
        rst_n = 1'b1;

        // legal back-to-back pulses on ch0: 1,0,1,0
        req_a = 4'b0001; step();
        check("t1_busy0", 32'(busy_a), 1);  check("t1_pulse0", 32'(pulse_a), 0);
        req_a = 4'b0000; step();
        check("t1_busy1", 32'(busy_a), 1);  check("t1_pulse1", 32'(pulse_a), 0);
        req_a = 4'b0001; step();
        check("t1_busy2", 32'(busy_a), 1);  check("t1_pulse2", 32'(pulse_a), 0);
        req_a = 4'b0000; step();
        check("t1_pulse3", 32'(pulse_a), 0);
        step();
        check("t1_busy4", 32'(busy_a), 0);  check("t1_cnt", 32'(cnt_a), 0);

        // ch1 held high for four samples: exactly one overlong report
        req_a = 4'b0010; step();
        check("t2_pulse_h1", 32'(pulse_a), 0);
        step();
        check("t2_pulse",  32'(pulse_a),  32'h2);
        check("t2_kind",   32'(kind_a),   32'h2);
        check("t2_cnt",    32'(cnt_a),    1);
        check("t2_sticky", 32'(sticky_a), 32'h2);
        step();
        check("t2_pulse_h3", 32'(pulse_a), 0);
        step();
        check("t2_pulse_h4", 32'(pulse_a), 0);  check("t2_cnt_h4", 32'(cnt_a), 1);
        req_a = 4'b0000; step(); step();
        check("t2_busy_end", 32'(busy_a), 0);  check("t2_sticky_hold", 32'(sticky_a), 32'h2);

        // MAX_HIGH=3, MIN_LOW=2: ch2 req 1,1,0,1 is a short-gap violation
        req_b = 4'b0100; step(); step();
        req_b = 4'b0000; step();
        check("t3_pulse_pre", 32'(pulse_b), 0);
        req_b = 4'b0100; step();
        check("t3_pulse",  32'(pulse_b),  32'h4);
        check("t3_kind",   32'(kind_b),   0);
        check("t3_cnt",    32'(cnt_b),    1);
        check("t3_sticky", 32'(sticky_b), 32'h4);
        req_b = 4'b0000; step();
        check("t3_pulse_off", 32'(pulse_b), 0);
        step(); step();
        check("t3_busy_end", 32'(busy_b), 0);

        // CNT_W=2: one violation, then two rounds of four simultaneous ones
        req_c = 4'b0001; step(); step();
        check("t4_cnt1", 32'(cnt_c), 1);
        req_c = 4'b0000; step(); step();
        req_c = 4'b1111; step(); step();
        check("t4_pulse_all", 32'(pulse_c), 32'hF);
        check("t4_kind_all",  32'(kind_c),  32'hF);
        check("t4_cnt_sat1",  32'(cnt_c),   3);
        req_c = 4'b0000; step(); step();
        req_c = 4'b1111; step(); step();
        check("t4_cnt_sat2", 32'(cnt_c), 3);
        req_c = 4'b0000; step(); step();
        check("t4_busy_end", 32'(busy_c), 0);

        // clear in the same cycle as a ch3 violation
        req_a = 4'b1000; step();
        clr_err = 1'b1; step();
        clr_err = 1'b0;
        check("t5_cnt",     32'(cnt_a),    1);
        check("t5_sticky",  32'(sticky_a), 32'h8);
        check("t5_pulse",   32'(pulse_a),  32'h8);
        check("t5_cnt_c",   32'(cnt_c),    0);
        check("t5_sticky_c",32'(sticky_c), 0);
        req_a = 4'b0000; step(); step();

        // asynchronous reset in the middle of a pulse
        req_a = 4'b0001; step();
        check("t6_busy_pre", 32'(busy_a), 1);
        rst_n = 1'b0; #1;
        check("t6_busy_rst",   32'(busy_a),   0);
        check("t6_cnt_rst",    32'(cnt_a),    0);
        check("t6_sticky_rst", 32'(sticky_a), 0);
        req_a = 4'b0000; step();
        rst_n = 1'b1;
        req_a = 4'b0001; step();
        check("t6_busy_post", 32'(busy_a), 1);  check("t6_pulse_post", 32'(pulse_a), 0);
        req_a = 4'b0000; step();
        check("t6_pulse_low", 32'(pulse_a), 0);
        step();
        check("t6_cnt_end", 32'(cnt_a), 0);  check("t6_busy_end", 32'(busy_a), 0);

        // en dropped mid-pulse, then restored while req still high
        req_a = 4'b0001; step();
        check("t7_busy_pre", 32'(busy_a), 1);
        en = 1'b0; step();
        check("t7_busy_dis",  32'(busy_a),  0);
        check("t7_pulse_dis", 32'(pulse_a), 0);
        en = 1'b1; step();
        check("t7_pulse_fresh", 32'(pulse_a), 0);
        check("t7_busy_fresh",  32'(busy_a),  1);
        req_a = 4'b0000; step();
        check("t7_pulse_low", 32'(pulse_a), 0);
        step();
        check("t7_busy_end", 32'(busy_a), 0);  check("t7_cnt_end", 32'(cnt_a), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
